// File: rtl/fir_pkg.sv
// Shared widths and arithmetic helpers for the transposed-form FIR.
// Exports: wide_t, acc_width, addr_width, rescale, sat_hi/lo, sat_clip/val.
package fir_pkg;

  typedef logic signed [63:0] wide_t;

  function automatic int acc_width(input int dw, input int guard);
    return dw + 1 + guard;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Q-format rescale of a full product back to data scale.
  function automatic wide_t rescale(input wide_t prod, input int cw,
                                    input logic rnd);
    wide_t bias;
    bias = rnd ? (wide_t'(1) <<< (cw - 2)) : wide_t'(0);
    return (prod + bias) >>> (cw - 1);
  endfunction

  function automatic wide_t sat_hi(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_lo(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction

  function automatic logic sat_clip(input wide_t v, input int dw);
    return (v > sat_hi(dw)) || (v < sat_lo(dw));
  endfunction

  function automatic wide_t sat_val(input wide_t v, input int dw);
    if (v > sat_hi(dw)) return sat_hi(dw);
    if (v < sat_lo(dw)) return sat_lo(dw);
    return v;
  endfunction

endpackage

// File: rtl/fir_transposed_mac_tap.sv
// One FIR tap: coefficient reg, registered rescaled product, partial sum.
// Ports: clk/rst/flush, sample+valid, coef write bus, p_valid, s_{k+1} in, s_k out.
module fir_mac_tap
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int ACC_W      = 29,
  parameter int ADDR_W     = 3,
  parameter int TAP_IDX    = 0,
  parameter int ROUND_EN   = 1,
  parameter int IS_FIRST   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic [DATA_WIDTH-1:0]   iv_din,
  input  logic                    i_din_valid,
  input  logic                    i_coef_we,
  input  logic [ADDR_W-1:0]       iv_coef_addr,
  input  logic [COEF_WIDTH-1:0]   iv_coef,
  input  logic                    i_p_valid,
  input  logic signed [ACC_W-1:0] iv_s_next,
  output logic signed [ACC_W-1:0] ov_s
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  logic [COEF_WIDTH-1:0]   coef_q, coef_d;
  logic signed [DATA_WIDTH:0] p_q, p_d;
  logic signed [ACC_W-1:0] s_q, s_d, sum_c;
  logic signed [PW-1:0]    din_x, coef_x, prod;

  always_comb begin
    din_x  = PW'($signed(iv_din));
    coef_x = PW'($signed(coef_q));
    prod   = din_x * coef_x;
    sum_c  = ACC_W'(p_q) + iv_s_next;
    coef_d = coef_q;
    if (i_coef_we && (iv_coef_addr == ADDR_W'(TAP_IDX)))
      coef_d = iv_coef;
    // Uses coef_q, so a same-cycle write only affects later samples.
    p_d = p_q;
    if (i_din_valid && !i_flush)
      p_d = (DATA_WIDTH+1)'(rescale(wide_t'(prod), COEF_WIDTH,
                                    ROUND_EN != 0));
    s_d = s_q;
    if (i_flush)
      s_d = '0;
    else if (i_p_valid)
      s_d = sum_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coef_q <= '0;
      p_q    <= '0;
      s_q    <= '0;
    end else begin
      coef_q <= coef_d;
      p_q    <= p_d;
      s_q    <= s_d;
    end
  end

  // Tap 0 feeds the output stage directly with p_0 + s_1.
  assign ov_s = (IS_FIRST != 0) ? sum_c : s_q;

endmodule

// File: rtl/fir_transposed_mac.sv
// N-tap transposed-form FIR with valid handshake, coef load, round, saturate.
// Ports: i_clk, i_rst, i_flush, iv_din/i_din_valid, coef bus, ov_dout/o_dout_valid/o_sat.
module fir_transposed_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int NUM_TAPS   = 8,
  parameter int GUARD_BITS = $clog2(NUM_TAPS) + 1,
  parameter int ROUND_EN   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic [DATA_WIDTH-1:0]       iv_din,
  input  logic                        i_din_valid,
  input  logic                        i_coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] iv_coef_addr,
  input  logic [COEF_WIDTH-1:0]       iv_coef,
  output logic [DATA_WIDTH-1:0]       ov_dout,
  output logic                        o_dout_valid,
  output logic                        o_sat
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, GUARD_BITS);
  localparam int ADDR_W = $clog2(NUM_TAPS);

  logic signed [ACC_W-1:0] s_w [NUM_TAPS+1];
  logic                    p_valid_q, p_valid_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    sat_q, sat_d;
  wide_t                   y_w;

  assign s_w[NUM_TAPS] = '0;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    fir_mac_tap #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .ACC_W      (ACC_W),
      .ADDR_W     (ADDR_W),
      .TAP_IDX    (k),
      .ROUND_EN   (ROUND_EN),
      .IS_FIRST   ((k == 0) ? 1 : 0)
    ) u_tap (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_flush      (i_flush),
      .iv_din       (iv_din),
      .i_din_valid  (i_din_valid),
      .i_coef_we    (i_coef_we),
      .iv_coef_addr (iv_coef_addr),
      .iv_coef      (iv_coef),
      .i_p_valid    (p_valid_q),
      .iv_s_next    (s_w[k+1]),
      .ov_s         (s_w[k])
    );
  end

  always_comb begin
    y_w          = wide_t'(s_w[0]);
    p_valid_d    = i_din_valid && !i_flush;
    dout_d       = dout_q;
    sat_d        = sat_q;
    dout_valid_d = 1'b0;
    if (!i_flush && p_valid_q) begin
      dout_d       = DATA_WIDTH'(sat_val(y_w, DATA_WIDTH));
      sat_d        = sat_clip(y_w, DATA_WIDTH);
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_valid_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      p_valid_q    <= p_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
    end
  end

  assign ov_dout      = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_sat        = sat_q;

endmodule

// File: tb/tb_fir_transposed_mac.sv
// Directed bench for fir_transposed_mac (8-bit data/coef).
// Round, truncate and 3-tap instances share one stimulus bus.
module tb_fir_transposed_mac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] din = '0;
  logic       din_v = 1'b0;
  logic       coef_we = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] coef = '0;

  logic [7:0] dout_r, dout_t, dout_3;
  logic       dv_r, dv_t, dv_3;
  logic       sat_r, sat_t, sat_3;

  int n_chk = 0;
  int n_pass = 0;
  int q_r[$], q_s[$], q_t[$], q_3[$];
  logic [7:0] last_r = '0;
  logic hold_chk = 1'b0;

  always #5 clk = ~clk;

  fir_transposed_mac #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(4), .ROUND_EN(1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .iv_din(din), .i_din_valid(din_v),
    .i_coef_we(coef_we), .iv_coef_addr(addr), .iv_coef(coef),
    .ov_dout(dout_r), .o_dout_valid(dv_r), .o_sat(sat_r)
  );

  fir_transposed_mac #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(4), .ROUND_EN(0)
  ) u_trn (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .iv_din(din), .i_din_valid(din_v),
    .i_coef_we(coef_we), .iv_coef_addr(addr), .iv_coef(coef),
    .ov_dout(dout_t), .o_dout_valid(dv_t), .o_sat(sat_t)
  );

  fir_transposed_mac #(
    .DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(3), .ROUND_EN(1)
  ) u_n3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .iv_din(din), .i_din_valid(din_v),
    .i_coef_we(coef_we), .iv_coef_addr(addr), .iv_coef(coef),
    .ov_dout(dout_3), .o_dout_valid(dv_3), .o_sat(sat_3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_q(input string tag, input int got[$],
                       input int exp[$]);
    chk($sformatf("%s_len", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size())
        chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  always @(negedge clk) begin
    if (dv_r) begin
      q_r.push_back(int'($signed(dout_r)));
      q_s.push_back(int'(sat_r));
      last_r = dout_r;
    end else if (hold_chk) begin
      chk("hold", int'($signed(dout_r)), int'($signed(last_r)));
    end
    if (dv_t) q_t.push_back(int'($signed(dout_t)));
    if (dv_3) q_3.push_back(int'($signed(dout_3)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    flush = 1'b0;
    coef_we = 1'b0;
    din_v = 1'b0;
    din = '0;
  endtask

  task automatic step(input logic [7:0] x, input logic v);
    din = x;
    din_v = v;
    tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic load4(input logic [7:0] h0, input logic [7:0] h1,
                       input logic [7:0] h2, input logic [7:0] h3);
    logic [7:0] h [4];
    h = '{h0, h1, h2, h3};
    for (int k = 0; k < 4; k++) begin
      coef_we = 1'b1;
      addr = 2'(k);
      coef = h[k];
      tick();
    end
  endtask

  task automatic clr();
    q_r.delete();
    q_s.delete();
    q_t.delete();
    q_3.delete();
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    drain(3);
    chk("rst_valid", int'(dv_r), 0);
    chk("rst_dout", int'(dout_r), 0);
    chk("rst_sat", int'(sat_r), 0);
    rst = 1'b0;
    tick();

    // impulse response and latency
    load4(8'h40, 8'h20, 8'h10, 8'h08);
    clr();
    step(8'h40, 1'b1);
    chk("lat_t1", int'(dv_r), 0);
    step(8'h00, 1'b1);
    chk("lat_t2", int'(dv_r), 1);
    chk("lat_dout", int'($signed(dout_r)), 32);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    drain(4);
    chk_q("imp", q_r, '{32, 16, 8, 4, 0});

    // rounding vs truncation
    do_flush();
    load4(8'h40, 8'h00, 8'h00, 8'h00);
    clr();
    step(8'h01, 1'b1);
    step(8'hFF, 1'b1);
    drain(4);
    chk_q("rnd", q_r, '{1, 0});
    chk_q("trn", q_t, '{0, -1});

    // saturation
    do_flush();
    load4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    clr();
    for (int i = 0; i < 4; i++) step(8'h7F, 1'b1);
    drain(4);
    chk_q("sat", q_r, '{126, 127, 127, 127});
    chk_q("satf", q_s, '{0, 1, 1, 1});
    do_flush();
    load4(8'h80, 8'h00, 8'h00, 8'h00);
    clr();
    step(8'h80, 1'b1);
    drain(4);
    chk_q("neg1", q_r, '{127});
    chk_q("neg1f", q_s, '{1});
    chk_q("neg1t", q_t, '{127});

    // sparse input, output holds between pulses
    do_flush();
    load4(8'h40, 8'h20, 8'h10, 8'h08);
    clr();
    hold_chk = 1'b1;
    step(8'h40, 1'b1);
    drain(2);
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b1);
      drain(2);
    end
    drain(2);
    hold_chk = 1'b0;
    chk_q("sparse", q_r, '{32, 16, 8, 4, 0});

    // coefficient write colliding with a sample
    do_flush();
    load4(8'h40, 8'h00, 8'h00, 8'h00);
    clr();
    coef_we = 1'b1;
    addr = 2'd0;
    coef = 8'h20;
    step(8'h40, 1'b1);
    step(8'h40, 1'b1);
    drain(4);
    chk_q("coll", q_r, '{32, 16});

    // addr 3 is out of range on the 3-tap instance
    do_flush();
    load4(8'h40, 8'h00, 8'h00, 8'h00);
    coef_we = 1'b1;
    addr = 2'd3;
    coef = 8'h7F;
    tick();
    clr();
    step(8'h40, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    drain(4);
    chk_q("ill3", q_3, '{32, 0, 0, 0});
    chk_q("ill4", q_r, '{32, 0, 0, 64});

    // flush mid-impulse
    do_flush();
    load4(8'h40, 8'h20, 8'h10, 8'h08);
    clr();
    step(8'h40, 1'b1);
    step(8'h00, 1'b1);
    flush = 1'b1;
    step(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    drain(4);
    chk_q("flush", q_r, '{32, 0, 0, 0, 0});
    clr();
    step(8'h40, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
    drain(4);
    chk_q("keep", q_r, '{32, 16, 8, 4});

    // reset mid-stream
    clr();
    step(8'h40, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", int'(dv_r), 0);
    step(8'h40, 1'b1);
    drain(4);
    chk_q("mrst", q_r, '{0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
